frame_read_arbiter: RTL and testbench

FRAME_READ_ARBITER -- requirements
Module: frame_read_arbiter

---
 rtl/frame_read_arbiter_pkg.sv | 23 ++
 rtl/frame_read_arbiter_if.sv | 59 +++++
 rtl/frame_read_arbiter_rd_tag_pipe.sv | 31 +++
 rtl/frame_read_arbiter.sv | 134 +++++++++++++
 tb/tb_frame_read_arbiter.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/frame_read_arbiter_pkg.sv
// Shared types and constants for the frame-buffer read arbiter.
// Frame geometry is 320x240 RGB444.
package frame_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

  localparam int ADDR_W_DEF    = 17;
  localparam int DATA_W_DEF    = 12;
  localparam int MAX_BURST_DEF = 80;

  localparam int FRAME_W = 320;
  localparam int FRAME_H = 240;

  typedef struct packed {
    logic valid;
    logic id;
  } rd_tag_t;

endpackage

// File: rtl/frame_read_arbiter_if.sv
// Requester, return and frame-memory signals of the read arbiter.
// slave = arbiter side, master = line-buffer/memory side.
interface frame_read_arbiter_if
  import frame_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) ();

  logic              frame_start;
  logic              req0;
  logic              req1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic              gnt0;
  logic              gnt1;
  logic              rvalid0;
  logic              rvalid1;
  logic [DATA_W-1:0] rdata;
  logic              mem_re;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;

  modport slave (
    input  frame_start,
    input  req0,
    input  req1,
    input  addr0,
    input  addr1,
    input  mem_rdata,
    output gnt0,
    output gnt1,
    output rvalid0,
    output rvalid1,
    output rdata,
    output mem_re,
    output mem_addr,
    output busy
  );

  modport master (
    output frame_start,
    output req0,
    output req1,
    output addr0,
    output addr1,
    output mem_rdata,
    input  gnt0,
    input  gnt1,
    input  rvalid0,
    input  rvalid1,
    input  rdata,
    input  mem_re,
    input  mem_addr,
    input  busy
  );

endinterface

// File: rtl/frame_read_arbiter_rd_tag_pipe.sv
// RD_LAT-deep {valid, id} shift register that follows each read
// from issue to the cycle its data is sampled.
module rd_tag_pipe
  import frame_arb_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic    clk,
  input  logic    rst_n,
  input  rd_tag_t tag_i,
  output rd_tag_t tag_o
);

  rd_tag_t pipe_q [RD_LAT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LAT; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q[0] <= tag_i;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign tag_o = pipe_q[RD_LAT-1];

endmodule

// File: rtl/frame_read_arbiter.sv
// Two-requester frame-buffer read arbiter with burst limit,
// zero-bubble owner switch and in-order tagged read return.
module frame_read_arbiter
  import frame_arb_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MAX_BURST = MAX_BURST_DEF,
  parameter int RD_LAT    = 1
) (
  input logic                 clk,
  input logic                 reset,
  frame_read_arbiter_if.slave bus
);

  localparam int CNT_W =
    ($clog2(MAX_BURST) > 0) ? $clog2(MAX_BURST) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(MAX_BURST - 1);

  arb_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              last_q, last_d;
  logic              mem_re_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              rv0_q, rv1_q;
  logic [DATA_W-1:0] rdata_q;
  logic              gnt0, gnt1, accept;
  rd_tag_t           tag_in, tag_out;

  always_comb begin
    state_d = state_q;
    if (bus.frame_start) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.req0 && bus.req1)
            state_d = last_q ? OWN0 : OWN1;
          else if (bus.req0)
            state_d = OWN0;
          else if (bus.req1)
            state_d = OWN1;
        end
        OWN0: begin
          if (bus.req0 && (cnt_q < CNT_MAX || !bus.req1))
            state_d = OWN0;
          else if (bus.req1)
            state_d = OWN1;
          else
            state_d = IDLE;
        end
        OWN1: begin
          if (bus.req1 && (cnt_q < CNT_MAX || !bus.req0))
            state_d = OWN1;
          else if (bus.req0)
            state_d = OWN0;
          else
            state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Gated by reset so grants stay low while the block is held in reset.
  assign gnt0   = reset & bus.req0 & (state_d == OWN0);
  assign gnt1   = reset & bus.req1 & (state_d == OWN1);
  assign accept = gnt0 | gnt1;

  always_comb begin
    cnt_d  = cnt_q;
    last_d = last_q;
    if (bus.frame_start) begin
      cnt_d  = '0;
      last_d = 1'b1;
    end else begin
      if (state_d != state_q)
        cnt_d = '0;
      else if (accept && cnt_q != CNT_MAX)
        cnt_d = cnt_q + 1'b1;
      unique case (1'b1)
        state_d == OWN0: last_d = 1'b0;
        state_d == OWN1: last_d = 1'b1;
        default:         last_d = last_q;
      endcase
    end
  end

  assign tag_in = '{valid: accept, id: gnt1};

  rd_tag_pipe #(
    .RD_LAT (RD_LAT)
  ) u_tags (
    .clk   (clk),
    .rst_n (reset),
    .tag_i (tag_in),
    .tag_o (tag_out)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      last_q     <= 1'b1;
      mem_re_q   <= 1'b0;
      mem_addr_q <= '0;
      rv0_q      <= 1'b0;
      rv1_q      <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      mem_re_q <= accept;
      if (accept)
        mem_addr_q <= gnt1 ? bus.addr1 : bus.addr0;
      rv0_q <= tag_out.valid & ~tag_out.id;
      rv1_q <= tag_out.valid & tag_out.id;
      if (tag_out.valid)
        rdata_q <= bus.mem_rdata;
    end
  end

  assign bus.gnt0     = gnt0;
  assign bus.gnt1     = gnt1;
  assign bus.mem_re   = mem_re_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.rvalid0  = rv0_q;
  assign bus.rvalid1  = rv1_q;
  assign bus.rdata    = rdata_q;
  assign bus.busy     = (state_q != IDLE);

endmodule

// File: tb/tb_frame_read_arbiter.sv
// Bench: three arbiters (RD_LAT 1..3, MAX_BURST 4) on shared stimulus,
// compared against an owner/run-length model and an issue log.
module tb_frame_read_arbiter;
  import frame_arb_pkg::*;

  localparam int AW = 17;
  localparam int DW = 12;
  localparam int MB = 4;
  localparam int NC = 8192;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic          fs = 1'b0, r0 = 1'b0, r1 = 1'b0;
  logic [AW-1:0] a0 = '0, a1 = '0;
  int            total = 0, bad = 0, cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  frame_read_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) b1 (), b2 (), b3 ();

  assign {b1.frame_start, b1.req0, b1.req1, b1.addr0, b1.addr1} =
    {fs, r0, r1, a0, a1};
  assign {b2.frame_start, b2.req0, b2.req1, b2.addr0, b2.addr1} =
    {fs, r0, r1, a0, a1};
  assign {b3.frame_start, b3.req0, b3.req1, b3.addr0, b3.addr1} =
    {fs, r0, r1, a0, a1};

  frame_read_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB),
    .RD_LAT(1)) u_dut1 (.clk(clk), .reset(reset), .bus(b1));
  frame_read_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB),
    .RD_LAT(2)) u_dut2 (.clk(clk), .reset(reset), .bus(b2));
  frame_read_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB),
    .RD_LAT(3)) u_dut3 (.clk(clk), .reset(reset), .bus(b3));

  function automatic logic [DW-1:0] memf(input logic [AW-1:0] a);
    logic [AW-1:0] t;
    t = a ^ (a >> 5);
    return t[DW-1:0] ^ 12'h5a3;
  endfunction

  // Memory data is sampled RD_LAT edges after the edge raising mem_re.
  logic [AW-1:0] p2a = '0, p3a = '0, p3b = '0;
  always @(posedge clk) begin
    p2a <= b2.mem_addr;
    p3a <= b3.mem_addr;
    p3b <= p3a;
  end
  assign b1.mem_rdata = memf(b1.mem_addr);
  assign b2.mem_rdata = memf(p2a);
  assign b3.mem_rdata = memf(p3b);

  logic [2:0]    g0, g1, rv0, rv1, mre, bsy;
  logic [DW-1:0] rd [3];
  logic [AW-1:0] ma [3];
  assign g0  = {b3.gnt0, b2.gnt0, b1.gnt0};
  assign g1  = {b3.gnt1, b2.gnt1, b1.gnt1};
  assign rv0 = {b3.rvalid0, b2.rvalid0, b1.rvalid0};
  assign rv1 = {b3.rvalid1, b2.rvalid1, b1.rvalid1};
  assign mre = {b3.mem_re, b2.mem_re, b1.mem_re};
  assign bsy = {b3.busy, b2.busy, b1.busy};
  assign rd[0] = b1.rdata;
  assign rd[1] = b2.rdata;
  assign rd[2] = b3.rdata;
  assign ma[0] = b1.mem_addr;
  assign ma[1] = b2.mem_addr;
  assign ma[2] = b3.mem_addr;

  // Reference: owner (-1 = none), beats granted in this ownership,
  // last winner, and a per-cycle log of issued reads.
  int            owner = -1, run = 0, last = 1;
  logic          exp_re = 1'b0;
  logic [AW-1:0] exp_ma = '0;
  bit            iv  [NC];
  bit            iid [NC];
  logic [AW-1:0] ia  [NC];

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    owner  = -1;
    run    = 0;
    last   = 1;
    exp_re = 1'b0;
    exp_ma = '0;
    for (int i = 0; i < NC; i++) iv[i] = 1'b0;
  endtask

  task automatic reset_dut();
    @(posedge clk);
    #3;
    r0 = 1'b1;
    r1 = 1'b1;
    fs = 1'b0;
    reset = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rst_gnt0[%0d]", k), 32'(g0[k]), 0);
      check($sformatf("rst_gnt1[%0d]", k), 32'(g1[k]), 0);
      check($sformatf("rst_re[%0d]", k), 32'(mre[k]), 0);
      check($sformatf("rst_rv0[%0d]", k), 32'(rv0[k]), 0);
      check($sformatf("rst_rv1[%0d]", k), 32'(rv1[k]), 0);
      check($sformatf("rst_busy[%0d]", k), 32'(bsy[k]), 0);
      check($sformatf("rst_rdata[%0d]", k), 32'(rd[k]), 0);
      check($sformatf("rst_addr[%0d]", k), 32'(ma[k]), 0);
    end
    repeat (2) @(posedge clk);
    r0 = 1'b0;
    r1 = 1'b0;
    #2;
    reset = 1'b1;
    model_reset();
  endtask

  task automatic step(input bit f, input bit q0, input bit q1,
                      input logic [AW-1:0] d0, input logic [AW-1:0] d1);
    int c, w, lat, src;
    bit ro, rx, ev;
    @(posedge clk);
    #1;
    fs = f;
    r0 = q0;
    r1 = q1;
    a0 = d0;
    a1 = d1;
    c  = cyc;
    @(negedge clk);
    if (f) w = -1;
    else if (owner < 0)
      w = (q0 && q1) ? (last == 1 ? 0 : 1) : q0 ? 0 : q1 ? 1 : -1;
    else begin
      ro = (owner == 1) ? q1 : q0;
      rx = (owner == 1) ? q0 : q1;
      if (ro && (run < MB || !rx)) w = owner;
      else if (rx) w = 1 - owner;
      else w = -1;
    end
    for (int k = 0; k < 3; k++) begin
      lat = k + 1;
      src = c - lat - 1;
      ev  = (src >= 0) && (src < NC) && iv[src];
      check($sformatf("gnt0[%0d]", k), 32'(g0[k]), 32'(w == 0));
      check($sformatf("gnt1[%0d]", k), 32'(g1[k]), 32'(w == 1));
      check($sformatf("busy[%0d]", k), 32'(bsy[k]), 32'(owner >= 0));
      check($sformatf("mem_re[%0d]", k), 32'(mre[k]), 32'(exp_re));
      check($sformatf("mem_addr[%0d]", k), 32'(ma[k]), 32'(exp_ma));
      check($sformatf("rvalid0[%0d]", k), 32'(rv0[k]),
            32'(ev && !iid[src]));
      check($sformatf("rvalid1[%0d]", k), 32'(rv1[k]),
            32'(ev && iid[src]));
      if (ev)
        check($sformatf("rdata[%0d]", k), 32'(rd[k]), 32'(memf(ia[src])));
    end
    if (c >= 0 && c < NC) begin
      iv[c]  = (w >= 0);
      iid[c] = (w == 1);
      ia[c]  = (w == 1) ? d1 : d0;
    end
    exp_re = (w >= 0);
    if (w >= 0) exp_ma = (w == 1) ? d1 : d0;
    if (f) begin
      owner = -1;
      run   = 0;
      last  = 1;
    end else if (w < 0) begin
      owner = -1;
      run   = 0;
    end else begin
      if (w == owner) run++;
      else begin
        owner = w;
        run   = 1;
      end
      last = w;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, '0, '0);
  endtask

  function automatic logic [AW-1:0] raddr();
    return AW'($urandom_range(0, FRAME_W * FRAME_H - 1));
  endfunction

  initial begin
    int n;
    model_reset();
    reset_dut();

    // single requester, addresses 0..4
    for (int i = 0; i < 5; i++) step(0, 1, 0, AW'(i), '0);
    idle(6);

    // tie straight after reset, then 4/4 burst alternation
    reset_dut();
    for (int k = 0; k < 16; k++) begin
      step(0, 1, 1, raddr(), raddr());
      check("tie_burst_gnt0", 32'(g0[0]), 32'(((k / 4) % 2) == 0));
    end
    idle(6);

    // frame_start while requester 1 owns after 2 beats
    reset_dut();
    step(0, 0, 1, '0, 17'd100);
    step(0, 0, 1, '0, 17'd101);
    step(1, 1, 1, 17'd200, 17'd102);
    check("fs_nogrant", 32'(g0[0] | g1[0]), 0);
    step(0, 1, 1, 17'd201, 17'd103);
    check("fs_then_gnt0", 32'(g0[0]), 1);
    n = 0;
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 0, '0, '0);
      n += int'(rv1[2]);
    end
    check("fs_rv1_beats", 32'(n), 2);

    // reset one cycle after a grant
    step(0, 1, 0, 17'd300, '0);
    reset_dut();
    idle(6);

    // randomized traffic with occasional frame_start and reset
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 299) == 0) reset_dut();
      step($urandom_range(0, 39) == 0,
           $urandom_range(0, 3) != 0,
           $urandom_range(0, 2) != 0,
           raddr(), raddr());
    end
    idle(6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
